// File: rtl/lift_pkg.sv
// Shared lift definitions: car state codes as seen by the display block,
// travel direction and the at-floor helpers.
package lift_pkg;

   localparam logic [2:0] ST_F0   = 3'b000;
   localparam logic [2:0] ST_UP01 = 3'b001;
   localparam logic [2:0] ST_F1   = 3'b010;
   localparam logic [2:0] ST_UP12 = 3'b011;
   localparam logic [2:0] ST_F2   = 3'b100;
   localparam logic [2:0] ST_DN21 = 3'b101;
   localparam logic [2:0] ST_DN10 = 3'b110;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   function automatic logic is_floor(input logic [2:0] st);
      return (st == ST_F0) || (st == ST_F1) || (st == ST_F2);
   endfunction

   // At-floor codes are 2*floor, so the index is simply the upper two bits.
   function automatic logic [1:0] floor_idx(input logic [2:0] st);
      return st[2:1];
   endfunction

endpackage

// File: rtl/lift_kontroler_if.sv
// Call buttons in, car state / door / pending-call LEDs out.
// master drives the buttons and watches the car; slave is the controller.
interface lift_kontroler_if;
   logic [2:0] req;
   logic [2:0] tstanje;
   logic       vrata;
   logic [2:0] pending;

   modport master (output req, input tstanje, vrata, pending);
   modport slave  (input req, output tstanje, vrata, pending);
endinterface

// File: rtl/lift_tajmer.sv
// Loadable saturating down-counter. done_o marks the edge on which the
// count expires (counter at 1 or already at 0).
module lift_tajmer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/lift_kontroler.sv
// Three-floor lift car controller: call latch, SCAN scheduling, travel and
// door timing. Optional auto-return to F0 when idle: LIFT_IDLE_HOME_EN.
module lift_kontroler
   import lift_pkg::*;
#(
   parameter int TRAVEL_CYC = 50_000_000,
   parameter int DOOR_CYC   = 100_000_000,
   parameter int HOME_CYC   = 250_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   lift_kontroler_if.slave   bus
);

   localparam int TW = $clog2(TRAVEL_CYC + 1);
   localparam int DW = $clog2(DOOR_CYC + 1);

   logic [2:0] tstanje_q, tstanje_d;
   logic       vrata_q, vrata_d;
   logic [2:0] pending_q, pending_d;
   logic       dir_q, dir_d;

   logic          trav_load, trav_dec, trav_done;
   logic          door_load, door_dec, door_done;
   logic [TW-1:0] trav_cnt;
   logic [DW-1:0] door_cnt;

   logic       at_floor, own_hold;
   logic [1:0] cur;
   logic [2:0] cur_mask, set_bits, clr_bits, home_bits;

   assign at_floor = is_floor(tstanje_q);
   assign cur      = floor_idx(tstanje_q);
   assign cur_mask = 3'b001 << cur;
   // A press at the floor whose doors are open only extends the dwell.
   assign own_hold = at_floor && vrata_q && ((bus.req & cur_mask) != 3'b000);
   assign set_bits = (bus.req & ~(own_hold ? cur_mask : 3'b000)) | home_bits;

`ifdef LIFT_IDLE_HOME_EN
   localparam int HW = $clog2(HOME_CYC + 1);
   logic          idle_cond, home_done;
   logic [HW-1:0] home_cnt;

   assign idle_cond = ((tstanje_q == ST_F1) || (tstanje_q == ST_F2)) && !vrata_q &&
                      (pending_q == 3'b000) && (bus.req == 3'b000);
   assign home_bits = (idle_cond && home_done) ? 3'b001 : 3'b000;

   lift_tajmer #(.W(HW)) u_home (
      .clk(clk), .rst_n(rst_n),
      .load_i(!idle_cond), .load_val_i(HW'(HOME_CYC)), .dec_i(idle_cond),
      .cnt_o(home_cnt), .done_o(home_done)
   );
`else
   assign home_bits = 3'b000;
`endif

   always_comb begin
      tstanje_d = tstanje_q;
      vrata_d   = vrata_q;
      dir_d     = dir_q;
      clr_bits  = 3'b000;
      trav_load = 1'b0;
      trav_dec  = 1'b0;
      door_load = 1'b0;
      door_dec  = 1'b0;
      if (!at_floor) begin
         trav_dec = 1'b1;
         if (trav_done) begin
            case (tstanje_q)
               ST_UP01, ST_DN21: tstanje_d = ST_F1;
               ST_UP12:          tstanje_d = ST_F2;
               default:          tstanje_d = ST_F0;
            endcase
         end
      end else if (vrata_q) begin
         if (own_hold) begin
            door_load = 1'b1;
         end else begin
            door_dec = 1'b1;
            if (door_done) vrata_d = 1'b0;
         end
      end else if ((pending_q & cur_mask) != 3'b000) begin
         vrata_d   = 1'b1;
         door_load = 1'b1;
         clr_bits  = cur_mask;
      end else begin
         // Decision cycle: keep heading the same way while calls remain ahead.
         case (tstanje_q)
            ST_F0: if (pending_q[1] || pending_q[2]) begin
               tstanje_d = ST_UP01; dir_d = DIR_UP; trav_load = 1'b1;
            end
            ST_F2: if (pending_q[0] || pending_q[1]) begin
               tstanje_d = ST_DN21; dir_d = DIR_DN; trav_load = 1'b1;
            end
            default: if ((dir_q == DIR_UP) && pending_q[2]) begin
               tstanje_d = ST_UP12; trav_load = 1'b1;
            end else if (pending_q[0]) begin
               tstanje_d = ST_DN10; dir_d = DIR_DN; trav_load = 1'b1;
            end else if (pending_q[2]) begin
               tstanje_d = ST_UP12; dir_d = DIR_UP; trav_load = 1'b1;
            end
         endcase
      end
      pending_d = (pending_q | set_bits) & ~clr_bits;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tstanje_q <= ST_F0;
         vrata_q   <= 1'b0;
         pending_q <= 3'b000;
         dir_q     <= DIR_UP;
      end else begin
         tstanje_q <= tstanje_d;
         vrata_q   <= vrata_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
      end
   end

   lift_tajmer #(.W(TW)) u_travel (
      .clk(clk), .rst_n(rst_n),
      .load_i(trav_load), .load_val_i(TW'(TRAVEL_CYC)), .dec_i(trav_dec),
      .cnt_o(trav_cnt), .done_o(trav_done)
   );

   lift_tajmer #(.W(DW)) u_door (
      .clk(clk), .rst_n(rst_n),
      .load_i(door_load), .load_val_i(DW'(DOOR_CYC)), .dec_i(door_dec),
      .cnt_o(door_cnt), .done_o(door_done)
   );

   assign bus.tstanje = tstanje_q;
   assign bus.vrata   = vrata_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_lift_kontroler.sv
// Directed bench for lift_kontroler with short timings (travel 4, door 3, home 20).
module tb_lift_kontroler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   lift_kontroler_if bus ();

   lift_kontroler #(.TRAVEL_CYC(4), .DOOR_CYC(3), .HOME_CYC(20)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got t/v/p=%b/%b/%b expected %b/%b/%b @%0t",
                  tag, got[6:4], got[3], got[2:0], exp[6:4], exp[3], exp[2:0], $time);
      end
   endtask

   function automatic logic [6:0] obs();
      return {bus.tstanje, bus.vrata, bus.pending};
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic expect_run(input string tag, input logic [2:0] t, input logic v,
                             input logic [2:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         chk(tag, obs(), {t, v, p});
      end
   endtask

   task automatic press(input logic [2:0] r);
      bus.req = r;
      cyc();
      bus.req = 3'b000;
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk(tag, obs(), 7'b000_0_000);
      expect_run({tag, "_hold"}, 3'b000, 1'b0, 3'b000, 2);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req = 3'b000;
      #3 chk("reset_async", obs(), 7'b000_0_000);
      repeat (2) cyc();
      rst_n = 1'b1;
      expect_run("reset_idle", 3'b000, 1'b0, 3'b000, 3);

      // own-floor call, then a second press while open extends the dwell
      press(3'b001);
      chk("own_latch", obs(), 7'b000_0_001);
      expect_run("own_open", 3'b000, 1'b1, 3'b000, 1);
      press(3'b001);
      chk("own_reload", obs(), 7'b000_1_000);
      expect_run("own_held", 3'b000, 1'b1, 3'b000, 2);
      expect_run("own_close", 3'b000, 1'b0, 3'b000, 2);

      // full trip F0 -> F2 with a non-stop pass through F1
      press(3'b100);
      chk("trip_latch", obs(), 7'b000_0_100);
      expect_run("trip_up01", 3'b001, 1'b0, 3'b100, 4);
      expect_run("trip_pass1", 3'b010, 1'b0, 3'b100, 1);
      expect_run("trip_up12", 3'b011, 1'b0, 3'b100, 4);
      expect_run("trip_arr2", 3'b100, 1'b0, 3'b100, 1);
      expect_run("trip_open2", 3'b100, 1'b1, 3'b000, 3);
      expect_run("trip_close2", 3'b100, 1'b0, 3'b000, 1);

`ifdef LIFT_IDLE_HOME_EN
      expect_run("home_wait", 3'b100, 1'b0, 3'b000, 19);
      expect_run("home_set", 3'b100, 1'b0, 3'b001, 1);
      expect_run("home_dn21", 3'b101, 1'b0, 3'b001, 4);
      expect_run("home_pass1", 3'b010, 1'b0, 3'b001, 1);
      expect_run("home_dn10", 3'b110, 1'b0, 3'b001, 4);
      expect_run("home_arr0", 3'b000, 1'b0, 3'b001, 1);
      expect_run("home_open0", 3'b000, 1'b1, 3'b000, 3);
      expect_run("home_close0", 3'b000, 1'b0, 3'b000, 1);
`else
      expect_run("stay_f2", 3'b100, 1'b0, 3'b000, 200);
`endif

      // SCAN: call to F0 while climbing to F2 is served after reversal
      async_reset("scan_reset");
      press(3'b100);
      chk("scan_latch", obs(), 7'b000_0_100);
      expect_run("scan_up01", 3'b001, 1'b0, 3'b100, 4);
      expect_run("scan_pass1", 3'b010, 1'b0, 3'b100, 1);
      expect_run("scan_up12a", 3'b011, 1'b0, 3'b100, 1);
      press(3'b001);
      chk("scan_up12b", obs(), 7'b011_0_101);
      expect_run("scan_up12c", 3'b011, 1'b0, 3'b101, 2);
      expect_run("scan_arr2", 3'b100, 1'b0, 3'b101, 1);
      expect_run("scan_open2", 3'b100, 1'b1, 3'b001, 3);
      expect_run("scan_dec2", 3'b100, 1'b0, 3'b001, 1);
      expect_run("scan_dn21", 3'b101, 1'b0, 3'b001, 4);
      expect_run("scan_pass1d", 3'b010, 1'b0, 3'b001, 1);
      expect_run("scan_dn10", 3'b110, 1'b0, 3'b001, 4);
      expect_run("scan_arr0", 3'b000, 1'b0, 3'b001, 1);
      expect_run("scan_open0", 3'b000, 1'b1, 3'b000, 3);
      expect_run("scan_close0", 3'b000, 1'b0, 3'b000, 1);

      // reset while moving 011, then a fresh call to F1
      press(3'b100);
      expect_run("mid_up01", 3'b001, 1'b0, 3'b100, 4);
      expect_run("mid_pass1", 3'b010, 1'b0, 3'b100, 1);
      expect_run("mid_up12", 3'b011, 1'b0, 3'b100, 1);
      async_reset("mid_reset");
      press(3'b010);
      chk("mid_latch", obs(), 7'b000_0_010);
      expect_run("mid_up01b", 3'b001, 1'b0, 3'b010, 4);
      expect_run("mid_arr1", 3'b010, 1'b0, 3'b010, 1);
      expect_run("mid_open1", 3'b010, 1'b1, 3'b000, 3);
      expect_run("mid_close1", 3'b010, 1'b0, 3'b000, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
